count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_count_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: IDLE/RUN/PAUSE/DONE sequencer that drives the reset and enable of a downstream up-counter.
// Optional build macro COUNT_CTRL_DEBOUNCE_EN debounces start/stop/clear over DB_CYCLES clocks.
module count_ctrl #(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned RUN_TICKS = 16,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic clear,
  output logic cnt_reset,
  output logic cnt_enable,
  output logic busy,
  output logic done
);

  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PRESCALE - 1);
  localparam logic [15:0]      TICK_LAST = 16'(RUN_TICKS);

  if (PRESCALE == 0 || PRESCALE > 256 || RUN_TICKS == 0 || RUN_TICKS > 65535 || DB_CYCLES == 0) begin : g_param_check
    $error("count_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_inc_s;
  logic [15:0]      tick_q, tick_d, tick_inc_s;
  logic             cnt_reset_q, cnt_reset_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0] raw_s;
  logic [2:0] cmd_s;
  logic       cmd_start_s, cmd_stop_s, cmd_clear_s;

  assign raw_s = {clear, stop, start};

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_FIRE = DB_W'(DB_CYCLES - 1);

  logic [2:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  // A command fires on its DB_CYCLES-th consecutive high sample; the saturated count blocks re-firing until the input drops.
  always_comb begin
    db_cnt_d = db_cnt_q;
    cmd_s    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (raw_s[i]) begin
        if (db_cnt_q[i] == DB_FULL) begin
          db_cnt_d[i] = DB_FULL;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
        cmd_s[i] = (db_cnt_q[i] == DB_FIRE);
      end else begin
        db_cnt_d[i] = '0;
        cmd_s[i]    = 1'b0;
      end
    end
  end

  // Debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  assign cmd_s = raw_s;
`endif

  assign cmd_start_s = cmd_s[0];
  assign cmd_stop_s  = cmd_s[1];
  assign cmd_clear_s = cmd_s[2];

  assign div_inc_s  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  assign tick_inc_s = tick_q + 16'd1;

  // Next state; the enable strobe is registered on the edge where the divider reaches its last value.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    tick_d       = tick_q;
    cnt_reset_d  = 1'b0;
    cnt_enable_d = 1'b0;

    if (cmd_clear_s) begin
      state_d     = ST_IDLE;
      div_d       = '0;
      tick_d      = 16'd0;
      cnt_reset_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cmd_start_s) begin
            state_d     = ST_RUN;
            div_d       = '0;
            tick_d      = 16'd0;
            cnt_reset_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (cmd_stop_s) begin
            state_d = ST_PAUSE;
          end else begin
            div_d = div_inc_s;
            if (div_inc_s == DIV_LAST) begin
              cnt_enable_d = 1'b1;
              tick_d       = tick_inc_s;
              if (tick_inc_s == TICK_LAST) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (cmd_start_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
          tick_d  = 16'd0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      tick_q       <= 16'd0;
      cnt_reset_q  <= 1'b1;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cnt_reset  = cnt_reset_q;
  assign cnt_enable = cnt_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: vector table plus hand sequences (PRESCALE=4, RUN_TICKS=5; second DUT PRESCALE=1).
module tb_count_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, stop, clear;
  logic cr0, ce0, bz0, dn0;
  logic cr1, ce1, bz1, dn1;

  int total = 0;
  int bad   = 0;

  count_ctrl #(.PRESCALE(4), .RUN_TICKS(5), .DB_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cnt_reset(cr0), .cnt_enable(ce0), .busy(bz0), .done(dn0)
  );

  count_ctrl #(.PRESCALE(1), .RUN_TICKS(3), .DB_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cnt_reset(cr1), .cnt_enable(ce1), .busy(bz1), .done(dn1)
  );

  typedef struct {
    string nm;
    logic  r, st, sp, cl;
    logic  cr, ce, bz, dn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic sp, input logic cl);
    @(negedge clk);
    reset = r; start = st; stop = sp; clear = cl;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then compare dut0 outputs after the sampling edge.
  task automatic cyc(input string nm, input logic r, input logic st, input logic sp, input logic cl,
                     input logic ecr, input logic ece, input logic ebz, input logic edn);
    step(r, st, sp, cl);
    chk({nm, ".cnt_reset"},  cr0, ecr);
    chk({nm, ".cnt_enable"}, ce0, ece);
    chk({nm, ".busy"},       bz0, ebz);
    chk({nm, ".done"},       dn0, edn);
    chk({nm, ".exclusive"},  cr0 & ce0, 1'b0);
  endtask

`ifdef COUNT_CTRL_DEBOUNCE_EN
  task automatic run_debounce();
    cyc("db_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("db_glitch", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("db_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("db_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("db_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 19; c++)
      cyc("db_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (c % 4 == 0), 1'b1, 1'b0);
    cyc("db_last", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc("db_held", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`else
  task automatic add(input string nm, input logic r, input logic st, input logic sp, input logic cl,
                     input logic cr, input logic ce, input logic bz, input logic dn);
    vec_t v;
    v.nm = nm; v.r = r; v.st = st; v.sp = sp; v.cl = cl;
    v.cr = cr; v.ce = ce; v.bz = bz; v.dn = dn;
    vecs.push_back(v);
  endtask

  // Each row: inputs sampled at an edge, outputs expected in the cycle after that edge.
  task automatic build_table();
    add("reset", 1, 0, 0, 0, 1, 0, 0, 0);
    add("start", 0, 1, 0, 0, 1, 0, 1, 0);
    for (int c = 2; c <= 19; c++) add("run", 0, 0, 0, 0, 0, (c % 4 == 0), 1, 0);
    add("fifth_pulse", 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) add("done_hold", 0, 0, 0, 0, 0, 0, 0, 1);
    add("done_stop", 0, 0, 1, 0, 0, 0, 0, 1);
    add("done_restart", 0, 1, 0, 0, 1, 0, 1, 0);
    add("run_start", 0, 1, 0, 0, 0, 0, 1, 0);
    add("run_start", 0, 1, 0, 0, 0, 0, 1, 0);
    add("run_start", 0, 1, 0, 0, 0, 1, 1, 0);
    for (int c = 5; c <= 12; c++) add("run", 0, 0, 0, 0, 0, (c % 4 == 0), 1, 0);
    add("clear", 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    add("idle_stop", 0, 0, 1, 0, 0, 0, 0, 0);
    add("idle_clear", 0, 0, 0, 1, 1, 0, 0, 0);
    add("idle_after", 0, 0, 0, 0, 0, 0, 0, 0);
    add("start", 0, 1, 0, 0, 1, 0, 1, 0);
    for (int c = 2; c <= 12; c++) add("run", 0, 0, 0, 0, 0, (c % 4 == 0), 1, 0);
    add("all_cmds", 0, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    add("start", 0, 1, 0, 0, 1, 0, 1, 0);
    for (int c = 2; c <= 5; c++) add("run", 0, 0, 0, 0, 0, (c % 4 == 0), 1, 0);
    add("mid_reset", 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    add("start", 0, 1, 0, 0, 1, 0, 1, 0);
    add("stop_start", 0, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add("paused", 0, 0, 0, 0, 0, 0, 1, 0);
    add("pause_clear", 0, 0, 0, 1, 1, 0, 0, 0);
    add("idle", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic seq_pause();
    cyc("p_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("p_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 9; c++) cyc("p_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (c % 4 == 0), 1'b1, 1'b0);
    cyc("p_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc("p_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("p_resume", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int r = 2; r <= 12; r++)
      cyc("p_run2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (r % 4 == 0), (r != 12), (r == 12));
    for (int i = 0; i < 3; i++) cyc("p_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Stop sampled on the edge where a pulse is due suppresses it; the pulse follows one cycle after resume.
  task automatic seq_stop_due();
    cyc("d_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("d_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("d_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("d_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("d_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("d_paused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("d_resume", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("d_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("d_clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic seq_p1();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1_reset.cnt_reset", cr1, 1'b1);
    chk("p1_reset.busy", bz1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("p1_c1.cnt_reset", cr1, 1'b1);
    chk("p1_c1.cnt_enable", ce1, 1'b0);
    chk("p1_c1.busy", bz1, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("p1_run.cnt_reset", cr1, 1'b0);
      chk("p1_run.cnt_enable", ce1, 1'b1);
      chk("p1_run.busy", bz1, (c != 4));
      chk("p1_run.done", dn1, (c == 4));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1_done.cnt_enable", ce1, 1'b0);
    chk("p1_done.done", dn1, 1'b1);
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef COUNT_CTRL_DEBOUNCE_EN
    run_debounce();
`else
    build_table();
    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].nm, vecs[i].r, vecs[i].st, vecs[i].sp, vecs[i].cl,
          vecs[i].cr, vecs[i].ce, vecs[i].bz, vecs[i].dn);
    seq_pause();
    seq_stop_due();
    seq_p1();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
